// File: rtl/cpu_stack_engine_if.sv
// Stack-engine bundle: control-side op handshake, SP load, pop return and byte-wide data-RAM port.
// The engine binds the slave modport; the requester/RAM side binds master.
interface cpu_stack_engine_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            sp_op;
    logic [15:0]           push_data;
    logic                  sp_load;
    logic [ADDR_WIDTH-1:0] sp_load_value;
    logic [ADDR_WIDTH-1:0] sp;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic                  mem_re;
    logic [7:0]            mem_rdata;
    logic [15:0]           pop_data;
    logic                  pop_valid;

    modport slave (
        input  op_valid, sp_op, push_data, sp_load, sp_load_value, mem_rdata,
        output op_ready, sp, mem_addr, mem_we, mem_wdata, mem_re, pop_data, pop_valid
    );

    modport master (
        output op_valid, sp_op, push_data, sp_load, sp_load_value, mem_rdata,
        input  op_ready, sp, mem_addr, mem_we, mem_wdata, mem_re, pop_data, pop_valid
    );
endinterface

// File: rtl/cpu_stack_engine.sv
// Executes one SP push/pop request as 1-2 byte beats on an 8-bit synchronous RAM; owns the stack pointer.
// Accept-to-ready 1..4 cycles; op_ready is low while a sequence runs, so requests simply wait.
module cpu_stack_engine #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET   = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_stack_engine_if.slave     stk
);
    typedef enum logic [2:0] {IDLE, WR0, WR1, RD0, RD1, RDLAST} state_t;

    localparam logic [2:0] SP_INC_1 = 3'd1;
    localparam logic [2:0] SP_INC_2 = 3'd2;
    localparam logic [2:0] SP_DEC_1 = 3'd3;
    localparam logic [2:0] SP_DEC_2 = 3'd4;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sp_q, sp_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic [15:0]           pop_data_q, pop_data_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  op_ready_q, op_ready_d;
    logic                  two_q, two_d;
    // Holds the second push byte, or the first popped byte until the pop completes.
    logic [7:0]            byte_q, byte_d;

    logic accept, is_push, is_pop, is_two;

    assign accept  = stk.op_valid && (state_q == IDLE) && !stk.sp_load;
    assign is_push = accept && (stk.sp_op == SP_DEC_1 || stk.sp_op == SP_DEC_2);
    assign is_pop  = accept && (stk.sp_op == SP_INC_1 || stk.sp_op == SP_INC_2);
    assign is_two  = (stk.sp_op == SP_INC_2 || stk.sp_op == SP_DEC_2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sp_q        <= SP_RESET;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            pop_data_q  <= 16'h0000;
            pop_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            two_q       <= 1'b0;
            byte_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            op_ready_q  <= op_ready_d;
            two_q       <= two_d;
            byte_q      <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_push) state_d = WR0;
                     else if (is_pop) state_d = RD0;
            WR0:     state_d = two_q ? WR1 : IDLE;
            WR1:     state_d = IDLE;
            RD0:     state_d = two_q ? RD1 : RDLAST;
            RD1:     state_d = RDLAST;
            RDLAST:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs are registered: this computes the values they take at the next edge.
    always_comb begin
        sp_d        = sp_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        op_ready_d  = (state_d == IDLE);
        two_d       = two_q;
        byte_d      = byte_q;
        case (state_q)
            IDLE: begin
                if (stk.sp_load) begin
                    sp_d = stk.sp_load_value;
                end else if (is_push) begin
                    two_d       = is_two;
                    byte_d      = stk.push_data[7:0];
                    mem_we_d    = 1'b1;
                    mem_addr_d  = sp_q;
                    mem_wdata_d = is_two ? stk.push_data[15:8] : stk.push_data[7:0];
                end else if (is_pop) begin
                    two_d      = is_two;
                    mem_re_d   = 1'b1;
                    mem_addr_d = sp_q + ADDR_WIDTH'(1);
                end
            end
            WR0: begin
                if (two_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = sp_q - ADDR_WIDTH'(1);
                    mem_wdata_d = byte_q;
                end else begin
                    sp_d = sp_q - ADDR_WIDTH'(1);
                end
            end
            WR1: sp_d = sp_q - ADDR_WIDTH'(2);
            RD0: begin
                if (two_q) begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = sp_q + ADDR_WIDTH'(2);
                end
            end
            RD1: byte_d = stk.mem_rdata;
            RDLAST: begin
                pop_data_d  = two_q ? {stk.mem_rdata, byte_q} : {8'h00, stk.mem_rdata};
                pop_valid_d = 1'b1;
                sp_d        = two_q ? sp_q + ADDR_WIDTH'(2) : sp_q + ADDR_WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign stk.op_ready  = op_ready_q;
    assign stk.sp        = sp_q;
    assign stk.mem_addr  = mem_addr_q;
    assign stk.mem_we    = mem_we_q;
    assign stk.mem_re    = mem_re_q;
    assign stk.mem_wdata = mem_wdata_q;
    assign stk.pop_data  = pop_data_q;
    assign stk.pop_valid = pop_valid_q;
endmodule

// File: tb/tb_cpu_stack_engine.sv
// Bench for cpu_stack_engine: directed table, sp_load/reset corner sequences, then random ops
// checked against a byte-array stack model with a synchronous RAM model attached to the port.
module tb_cpu_stack_engine;
    localparam int          AW  = 16;
    localparam logic [15:0] SPR = 16'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_stack_engine_if #(.ADDR_WIDTH(AW)) bus ();
    cpu_stack_engine #(.ADDR_WIDTH(AW), .SP_RESET(SPR)) dut (.clk(clk), .rst(rst), .stk(bus));

    bit   [7:0]  ram     [0:65535];
    bit   [7:0]  ref_mem [0:65535];
    logic [15:0] ref_sp;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op from a negedge; returns at the negedge where op_ready is back.
    task automatic run_op(input logic [2:0] op, input logic [15:0] data, output logic [15:0] got_pop);
        bit          push, pop;
        int          nb, exp_lat, lat, pcnt, moved, both;
        logic [15:0] s, a, exp_pop;
        logic [7:0]  b;
        logic [31:0] exp_w[$], got_w[$], exp_r[$], got_r[$];
        string       tag;
        tag     = $sformatf("op%0d@%04h", op, ref_sp);
        push    = (op == 3'd3 || op == 3'd4);
        pop     = (op == 3'd1 || op == 3'd2);
        nb      = (op == 3'd2 || op == 3'd4) ? 2 : ((push || pop) ? 1 : 0);
        exp_lat = push ? nb + 1 : (pop ? nb + 2 : 1);
        s       = ref_sp;
        exp_pop = 16'h0000;
        got_pop = 16'h0000;
        for (int i = 0; i < nb; i++) begin
            if (push) begin
                a = s - 16'(i);
                b = (i == nb - 1) ? data[7:0] : data[15:8];
                exp_w.push_back({8'(i + 1), a, b});
                ref_mem[a] = b;
            end else begin
                a = s + 16'(i + 1);
                exp_r.push_back({8'(i + 1), a, 8'h00});
                exp_pop = exp_pop | (16'(ref_mem[a]) << (8 * i));
            end
        end
        if (push) ref_sp = s - 16'(nb);
        if (pop)  ref_sp = s + 16'(nb);

        bus.op_valid  = 1'b1;
        bus.sp_op     = op;
        bus.push_data = data;
        bus.sp_load   = 1'b0;
        @(posedge clk);
        #1;
        bus.op_valid  = 1'b0;
        bus.push_data = 16'($urandom);
        lat = 0; pcnt = 0; moved = 0; both = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_re) both++;
            if (bus.mem_we) got_w.push_back({8'(k), bus.mem_addr, bus.mem_wdata});
            if (bus.mem_re) got_r.push_back({8'(k), bus.mem_addr, 8'h00});
            if (bus.pop_valid) begin
                pcnt++;
                got_pop = bus.pop_data;
            end
            if (bus.op_ready) begin
                lat = k;
                bus.sp_load = 1'b0;
                break;
            end
            if (bus.sp !== s) moved = 1;
            // sp_load while busy must be ignored
            bus.sp_load       = ($urandom_range(0, 3) == 0);
            bus.sp_load_value = 16'($urandom);
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " write count"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            chk($sformatf("%s write%0d {cyc,addr,data}", tag, i), got_w[i], exp_w[i]);
        chk({tag, " read count"}, got_r.size(), exp_r.size());
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
            chk($sformatf("%s read%0d {cyc,addr}", tag, i), got_r[i], exp_r[i]);
        chk({tag, " pop_valid pulses"}, pcnt, pop ? 1 : 0);
        if (pop) chk({tag, " pop_data"}, got_pop, exp_pop);
        chk({tag, " final sp"}, bus.sp, ref_sp);
        chk({tag, " sp moved mid-sequence"}, moved, 0);
        chk({tag, " we and re together"}, both, 0);
    endtask

    task automatic do_load(input logic [15:0] v, input logic ov, input logic [2:0] op);
        bus.sp_load       = 1'b1;
        bus.sp_load_value = v;
        bus.op_valid      = ov;
        bus.sp_op         = op;
        @(posedge clk);
        #1;
        bus.sp_load  = 1'b0;
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("load sp", bus.sp, v);
        chk("load op_ready", bus.op_ready, 1'b1);
        chk("load no strobes", {bus.mem_we, bus.mem_re}, 2'b00);
        ref_sp = v;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic [15:0] exp_sp;
        logic [15:0] exp_pop;
    } vec_t;

    vec_t        tbl[10];
    logic [15:0] pd;

    initial begin
        tbl[0] = '{3'd4, 16'hBEEF, 16'hFFFD, 16'h0000};
        tbl[1] = '{3'd2, 16'h0000, 16'hFFFF, 16'hBEEF};
        tbl[2] = '{3'd3, 16'h0012, 16'hFFFE, 16'h0000};
        tbl[3] = '{3'd1, 16'h0000, 16'hFFFF, 16'h0012};
        tbl[4] = '{3'd6, 16'h5555, 16'hFFFF, 16'h0000};
        tbl[5] = '{3'd0, 16'hAAAA, 16'hFFFF, 16'h0000};
        tbl[6] = '{3'd4, 16'hA55A, 16'hFFFD, 16'h0000};
        tbl[7] = '{3'd1, 16'h0000, 16'hFFFE, 16'h005A};
        tbl[8] = '{3'd1, 16'h0000, 16'hFFFF, 16'h00A5};
        tbl[9] = '{3'd7, 16'h0000, 16'hFFFF, 16'h0000};

        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        bus.op_valid = 1'b0; bus.sp_op = 3'd0; bus.push_data = 16'h0000;
        bus.sp_load = 1'b0; bus.sp_load_value = 16'h0000;
        ref_sp = SPR;

        repeat (3) @(negedge clk);
        chk("reset sp", bus.sp, SPR);
        chk("reset op_ready", bus.op_ready, 1'b1);
        chk("reset strobes", {bus.mem_we, bus.mem_re, bus.pop_valid}, 3'b000);
        chk("reset mem_addr", bus.mem_addr, 16'h0000);
        chk("reset mem_wdata", bus.mem_wdata, 8'h00);
        chk("reset pop_data", bus.pop_data, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].data, pd);
            chk($sformatf("table%0d sp", i), bus.sp, tbl[i].exp_sp);
            if (tbl[i].op == 3'd1 || tbl[i].op == 3'd2)
                chk($sformatf("table%0d pop_data", i), pd, tbl[i].exp_pop);
        end

        // sp_load wins over a same-cycle op; the op goes in on the next cycle and wraps.
        do_load(16'h0000, 1'b1, 3'd4);
        run_op(3'd4, 16'h1234, pd);
        chk("wrap push sp", bus.sp, 16'hFFFE);
        run_op(3'd2, 16'h0000, pd);
        chk("wrap pop data", pd, 16'h1234);
        chk("wrap pop sp", bus.sp, 16'h0000);

        // reset during the first read beat of a 2-byte pop
        do_load(16'h1000, 1'b0, 3'd0);
        bus.op_valid = 1'b1;
        bus.sp_op    = 3'd2;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("abort first read", {bus.mem_re, bus.mem_addr}, {1'b1, 16'h1001});
        rst = 1'b1;
        @(negedge clk);
        chk("abort strobes", {bus.mem_we, bus.mem_re, bus.pop_valid}, 3'b000);
        chk("abort sp", bus.sp, SPR);
        chk("abort op_ready", bus.op_ready, 1'b1);
        chk("abort mem_addr", bus.mem_addr, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("abort after strobes", {bus.mem_we, bus.mem_re, bus.pop_valid}, 3'b000);
        chk("abort after sp", bus.sp, SPR);
        ref_sp = SPR;

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0)
                do_load(16'($urandom), 1'($urandom), 3'($urandom));
            else
                run_op(3'($urandom_range(0, 7)), 16'($urandom), pd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_stack_engine.md
# cpu_stack_engine

Stack-side executor for the CPU's `sp_operation_t` requests. It receives a single SP operation from the control path and carries out the byte-wide memory beats it needs: 1- or 2-byte pushes and pops against the 8-bit data RAM. It owns the architectural stack pointer and returns popped data, such as return addresses for `FETCH_RET`, to the register-file and fetch side. It sits between the control unit and the data-memory port, alongside the AGU.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: width of the stack pointer and memory address.
- `SP_RESET`, default `16'hFFFF`: SP value after reset.

Ports:
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: reset, synchronous and active-high.
- `op_valid` in 1: a stack operation is offered this cycle.
- `op_ready` out 1: the engine is idle and can accept. Registered; cleared by the terms listed under Operation.
- `sp_op` in 3: `sp_operation_t` encoding. 0=`SP_NOP`, 1=`SP_INC_1`, 2=`SP_INC_2`, 3=`SP_DEC_1`, 4=`SP_DEC_2`.
- `push_data` in 16: data to push. A 1-byte push uses `[7:0]`.
- `sp_load` in 1: overwrite SP with `sp_load_value`.
- `sp_load_value` in `ADDR_WIDTH`: new SP value.
- `sp` out `ADDR_WIDTH`: current stack pointer.
- `mem_addr` out `ADDR_WIDTH`: data-RAM address.
- `mem_we` out 1: write strobe.
- `mem_wdata` out 8: write data.
- `mem_re` out 1: read strobe.
- `mem_rdata` in 8: read data, valid the cycle after `mem_re`. The RAM is synchronous.
- `pop_data` out 16: popped value. A 1-byte pop zero-extends.
- `pop_valid` out 1: one-cycle pulse when `pop_data` is updated.

## Operation
Stack model:
- Empty-descending: SP points at the next free byte.
- A push is `SP_DEC_*`; a pop is `SP_INC_*`.

Acceptance:
- An operation is accepted when `op_valid && op_ready && !sp_load`.
- `op_ready` is 1 only in `IDLE`.
- Encodings 5–7 are treated as `SP_NOP`.
- `SP_NOP` is accepted with no beats. The engine stays in `IDLE` and `op_ready` stays 1.
- On accept, the engine captures `sp_op` and `push_data`. The base SP is the current `sp` value.

`sp_load`:
- Honoured only in `IDLE`.
- Takes priority over `op_valid`: the op is not accepted that cycle.
- SP takes `sp_load_value` on the next cycle.
- `sp_load` is ignored outside `IDLE`.

Beat sequences (S = base SP):
- **`SP_DEC_1`:** write `[7:0]` to S. Final SP = S-1.
- **`SP_DEC_2`:** write `[15:8]` to S, then `[7:0]` to S-1. Final SP = S-2.
- **`SP_INC_1`:** read S+1 into `pop_data[7:0]`; `[15:8]` = 0. Final SP = S+1.
- **`SP_INC_2`:** read S+1 into `[7:0]`, then S+2 into `[15:8]`. Final SP = S+2.

State machine:
- `IDLE`: accept, then go to `WR0` or `RD0`.
- `WR0`: go to `WR1` (2-byte push) or `IDLE`.
- `WR1`: go to `IDLE`.
- `RD0`: go to `RD1` (2-byte pop) or `RDLAST`.
- `RD1`: go to `RDLAST`.
- `RDLAST`: capture the final byte, then go to `IDLE` and pulse `pop_valid`.

Arithmetic and boundaries:
- All SP and address arithmetic is mod 2^`ADDR_WIDTH`, wrapping silently with no fault.
- Example: S=0 with `SP_DEC_2` writes 0x0000, then 0xFFFF; final SP=0xFFFE.
- Example: S=0xFFFF with `SP_INC_2` reads 0x0000, then 0x0001.
- `mem_we` and `mem_re` are never asserted in the same cycle.
- Both strobes are 0 in `IDLE` and `RDLAST`.

Reset (including mid-operation):
- State goes to `IDLE`; `sp`=`SP_RESET`; `op_ready`=1.
- `mem_we`=`mem_re`=0; `mem_addr`=0; `mem_wdata`=0.
- `pop_data`=0; `pop_valid`=0.
- No further beats of an aborted op are issued, and no partial SP update survives.

## Timing
Accept in cycle A. Strobes and addresses are registered outputs:
- **`SP_DEC_1`:** write beat in A+1. `op_ready`=1 and SP=S-1 visible at A+2.
- **`SP_DEC_2`:** write beats in A+1 and A+2. Ready and SP=S-2 at A+3.
- **`SP_INC_1`:** `mem_re` at A+1 (addr S+1); capture in A+2. `pop_valid`, ready and SP=S+1 at A+3.
- **`SP_INC_2`:** reads at A+1 and A+2; captures at A+2 and A+3. `pop_valid`, ready and SP=S+2 at A+4.

Throughput and updates:
- Back-to-back ops are possible: a new op may be accepted in the cycle ready returns.
- `sp` changes only at op completion or on `sp_load`, never mid-sequence.

## Test plan
- Reset, then idle: `sp`=0xFFFF, `op_ready`=1, all strobes 0, `pop_valid`=0.
- `SP_DEC_2` with `push_data`=0xBEEF from S=0xFFFF: writes 0xBE@0xFFFF (A+1) and 0xEF@0xFFFE (A+2); SP=0xFFFD at A+3. Then `SP_INC_2` reads 0xFFFE and 0xFFFF; `pop_data`=0xBEEF with `pop_valid` at A+4; SP=0xFFFF.
- `sp_load`=1 with value 0x0000 and `op_valid` with `SP_DEC_2` in the same cycle: op not accepted, SP=0. Next cycle the op is accepted and writes 0x0000, then 0xFFFF; SP=0xFFFE.
- `SP_DEC_1` with 0x12, then `SP_INC_1` back-to-back: `pop_data`=0x0012, SP restored; exactly one `pop_valid` pulse.
- `rst` asserted in A+1 of `SP_INC_2`: no read at A+2, no `pop_valid`, SP=`SP_RESET`, `op_ready`=1 at A+2.
- `sp_op`=6 and `sp_op`=0 offered: no strobes, SP unchanged, `op_ready` stays 1.
